mem_req_arbiter: RTL and testbench

//  N-channel arbiter between cache refill/store requesters (I$, D$, uncached, ...) and one axi_interface port.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_req_arbiter_rr_pick.sv | 39 +++
 rtl/mem_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_req_arbiter: FSM encoding, transfer size codes,
// and the grant-index width helper.
package mem_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Index width for n channels, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker. Searches req_i starting at
// ptr_i and wrapping; ptr_i tied to zero gives plain lowest-index priority.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  localparam logic [W:0] NL = (W+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  // Rotate so the pointer channel lands at bit 0.
  assign dbl = {req_i, req_i};
  assign rot = N'(dbl >> ptr_i);

  // First set bit of the rotated vector, mapped back to a channel index.
  always_comb begin
    vld_o = 1'b0;
    off   = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (rot[j]) begin
        vld_o = 1'b1;
        off   = W'(j);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NL) sum = sum - NL;
    idx_o = sum[W-1:0];
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-channel arbiter in front of one axi_interface port.
// A grant is held for a whole transaction; read data is broadcast and the
// completion pulse goes only to the granted channel.
// Optional macro MEM_ARB_PERF_EN adds per-channel saturating perf counters.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1,
  parameter int CNT_W  = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
  input  logic [NUM_CH-1:0]            req_access,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*2-1:0]          req_size,
  input  logic [NUM_CH*DATA_W/8-1:0]   req_sel,
  input  logic [NUM_CH*DATA_W-1:0]     req_st_data,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [DATA_W-1:0]            req_data,
  output logic [ADDR_W-1:0]            mem_a,
  output logic                         mem_access,
  output logic                         mem_write,
  output logic [1:0]                   mem_size,
  output logic [DATA_W/8-1:0]          mem_sel,
  output logic [DATA_W-1:0]            mem_st_data,
  input  logic                         mem_ready,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         busy,
  output logic [NUM_CH*CNT_W-1:0]      perf_grant_cnt,
  output logic [NUM_CH*CNT_W-1:0]      perf_wait_cnt
);

  localparam int GW = idx_w(NUM_CH);
  localparam int SW = DATA_W/8;

  logic [NUM_CH-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CH-1:0][1:0]        size_v;
  logic [NUM_CH-1:0][SW-1:0]     sel_v;
  logic [NUM_CH-1:0][DATA_W-1:0] st_v;

  assign addr_v = req_addr;
  assign size_v = req_size;
  assign sel_v  = req_sel;
  assign st_v   = req_st_data;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_nxt, pick_ptr, pick_idx;
  logic          pick_vld;

  assign busy      = (state_q == ST_BUSY);
  assign req_data  = mem_data;
  assign pick_ptr  = (RR_EN != 0) ? rr_ptr_q : '0;
  assign grant_nxt = (grant_q == GW'(NUM_CH-1)) ? '0 : grant_q + GW'(1);

  rr_pick #(.N(NUM_CH), .W(GW)) u_pick (
    .req_i (req_access),
    .ptr_i (pick_ptr),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // Next state: latch winner in IDLE, release on mem_ready in BUSY.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE) begin
      if (pick_vld) begin
        grant_d = pick_idx;
        state_d = ST_BUSY;
      end
    end else if (mem_ready) begin
      state_d = ST_IDLE;
      if (RR_EN != 0) rr_ptr_d = grant_nxt;
    end
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Master port mux from the registered grant; idle outside BUSY.
  always_comb begin
    mem_a       = '0;
    mem_access  = 1'b0;
    mem_write   = 1'b0;
    mem_size    = '0;
    mem_sel     = '0;
    mem_st_data = '0;
    req_ready   = '0;
    if (busy) begin
      mem_a       = addr_v[grant_q];
      mem_access  = req_access[grant_q];
      mem_write   = req_write[grant_q];
      mem_size    = size_v[grant_q];
      mem_sel     = sel_v[grant_q];
      mem_st_data = st_v[grant_q];
      if (mem_ready) req_ready[grant_q] = 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_perf
    logic [CNT_W-1:0] gcnt_q, wcnt_q;
    logic             gnt_evt, wait_evt;

    assign gnt_evt  = !busy && pick_vld && (pick_idx == GW'(i));
    assign wait_evt = req_access[i] && !(busy && (grant_q == GW'(i)));

    // Saturating grant and wait counters for this channel.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        gcnt_q <= '0;
        wcnt_q <= '0;
      end else begin
        if (gnt_evt && (gcnt_q != '1))  gcnt_q <= gcnt_q + CNT_W'(1);
        if (wait_evt && (wcnt_q != '1)) wcnt_q <= wcnt_q + CNT_W'(1);
      end
    end

    assign perf_grant_cnt[i*CNT_W +: CNT_W] = gcnt_q;
    assign perf_wait_cnt[i*CNT_W +: CNT_W]  = wcnt_q;
  end
`else
  assign perf_grant_cnt = '0;
  assign perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: three instances cover 2-ch round-robin
// (CNT_W=4), 2-ch fixed priority and 3-ch round-robin.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  logic [31:0] mdata = 32'hCAFE_F00D;

  localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0000;
  localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB100_0000;

  // Instance A: 2 channels, round-robin, 4-bit counters
  logic [63:0] a_addr = {A1, A0};
  logic [1:0]  a_acc = '0, a_wr = '0, a_rdy;
  logic [3:0]  a_size = '0;
  logic [7:0]  a_sel = '0, a_pg, a_pw;
  logic [63:0] a_st = '0;
  logic [31:0] a_rdata, a_ma, a_mst;
  logic        a_macc, a_mwr, a_busy, a_mrdy = 1'b0;
  logic [1:0]  a_msize;
  logic [3:0]  a_msel;

  mem_req_arbiter #(.NUM_CH(2), .RR_EN(1), .CNT_W(4)) dut_a (
    .aclk(clk), .aresetn(rst_n), .req_addr(a_addr), .req_access(a_acc),
    .req_write(a_wr), .req_size(a_size), .req_sel(a_sel), .req_st_data(a_st),
    .req_ready(a_rdy), .req_data(a_rdata), .mem_a(a_ma), .mem_access(a_macc),
    .mem_write(a_mwr), .mem_size(a_msize), .mem_sel(a_msel), .mem_st_data(a_mst),
    .mem_ready(a_mrdy), .mem_data(mdata), .busy(a_busy),
    .perf_grant_cnt(a_pg), .perf_wait_cnt(a_pw));

  // Instance B: 2 channels, fixed priority
  logic [63:0]  b_addr = {B1, B0};
  logic [1:0]   b_acc = '0, b_wr = '0, b_rdy;
  logic [3:0]   b_size = '0;
  logic [7:0]   b_sel = '0;
  logic [63:0]  b_st = '0, b_pg, b_pw;
  logic [31:0]  b_rdata, b_ma, b_mst;
  logic         b_macc, b_mwr, b_busy, b_mrdy = 1'b0;
  logic [1:0]   b_msize;
  logic [3:0]   b_msel;

  mem_req_arbiter #(.NUM_CH(2), .RR_EN(0)) dut_b (
    .aclk(clk), .aresetn(rst_n), .req_addr(b_addr), .req_access(b_acc),
    .req_write(b_wr), .req_size(b_size), .req_sel(b_sel), .req_st_data(b_st),
    .req_ready(b_rdy), .req_data(b_rdata), .mem_a(b_ma), .mem_access(b_macc),
    .mem_write(b_mwr), .mem_size(b_msize), .mem_sel(b_msel), .mem_st_data(b_mst),
    .mem_ready(b_mrdy), .mem_data(mdata), .busy(b_busy),
    .perf_grant_cnt(b_pg), .perf_wait_cnt(b_pw));

  // Instance C: 3 channels, round-robin
  logic [95:0]  c_addr = {32'hC200_0000, 32'hC100_0000, 32'hC000_0000};
  logic [2:0]   c_acc = '0, c_wr = '0, c_rdy;
  logic [5:0]   c_size = '0;
  logic [11:0]  c_sel = '0;
  logic [95:0]  c_st = '0, c_pg, c_pw;
  logic [31:0]  c_rdata, c_ma, c_mst;
  logic         c_macc, c_mwr, c_busy, c_mrdy = 1'b0;
  logic [1:0]   c_msize;
  logic [3:0]   c_msel;

  mem_req_arbiter #(.NUM_CH(3), .RR_EN(1)) dut_c (
    .aclk(clk), .aresetn(rst_n), .req_addr(c_addr), .req_access(c_acc),
    .req_write(c_wr), .req_size(c_size), .req_sel(c_sel), .req_st_data(c_st),
    .req_ready(c_rdy), .req_data(c_rdata), .mem_a(c_ma), .mem_access(c_macc),
    .mem_write(c_mwr), .mem_size(c_msize), .mem_sel(c_msel), .mem_st_data(c_mst),
    .mem_ready(c_mrdy), .mem_data(mdata), .busy(c_busy),
    .perf_grant_cnt(c_pg), .perf_wait_cnt(c_pw));

  // Requester contract: a granted channel must keep its strobe up.
  always @(negedge clk) begin
    if (rst_n && ((a_busy && !a_macc) || (b_busy && !b_macc) || (c_busy && !c_macc)))
      $error("requester dropped access while granted");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    mid();
    vecs++; if (a_busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", a_busy); end
    vecs++; if (a_macc !== 1'b0) begin miss++; $display("FAIL reset_macc got %b want 0", a_macc); end
    vecs++; if (a_rdy !== 2'b00) begin miss++; $display("FAIL reset_rdy got %b want 00", a_rdy); end
    vecs++; if ({b_busy, c_busy, c_rdy} !== 5'b0) begin miss++; $display("FAIL reset_bc got %b want 0", {b_busy, c_busy, c_rdy}); end
    vecs++; if ({a_pg, a_pw} !== 16'h0) begin miss++; $display("FAIL reset_perf got %h want 0", {a_pg, a_pw}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_rr2();
    tick(); a_acc = 2'b11; mid();
    vecs++; if (a_macc !== 1'b0) begin miss++; $display("FAIL rr2_c0_macc got %b want 0", a_macc); end
    tick(); mid();
    vecs++; if ({a_busy, a_macc, a_ma} !== {2'b11, A0}) begin miss++; $display("FAIL rr2_grant0 got %b%b %h want 11 %h", a_busy, a_macc, a_ma, A0); end
    tick(); a_mrdy = 1'b1; mid();
    vecs++; if (a_rdy !== 2'b01) begin miss++; $display("FAIL rr2_rdy0 got %b want 01", a_rdy); end
    tick(); a_mrdy = 1'b0; a_acc = 2'b10; mid();
    vecs++; if ({a_busy, a_rdy} !== 3'b000) begin miss++; $display("FAIL rr2_bubble got %b want 000", {a_busy, a_rdy}); end
    tick(); mid();
    vecs++; if ({a_macc, a_ma} !== {1'b1, A1}) begin miss++; $display("FAIL rr2_grant1 got %b %h want 1 %h", a_macc, a_ma, A1); end
    tick(); a_mrdy = 1'b1; mid();
    vecs++; if (a_rdy !== 2'b10) begin miss++; $display("FAIL rr2_rdy1 got %b want 10", a_rdy); end
    vecs++; if (a_rdata !== 32'hCAFE_F00D) begin miss++; $display("FAIL rr2_rdata got %h want cafef00d", a_rdata); end
    tick(); a_mrdy = 1'b0; a_acc = 2'b11; mid();
    tick(); mid();
    vecs++; if (a_ma !== A0) begin miss++; $display("FAIL rr2_ptr_wrap got %h want %h", a_ma, A0); end
    tick(); a_mrdy = 1'b1; mid();
    vecs++; if (a_rdy !== 2'b01) begin miss++; $display("FAIL rr2_rdy0b got %b want 01", a_rdy); end
    tick(); a_mrdy = 1'b0; a_acc = 2'b00;
  endtask

  task automatic test_fixed();
    tick(); b_mrdy = 1'b1; mid();
    vecs++; if (b_rdy !== 2'b00) begin miss++; $display("FAIL fix_idle_ready got %b want 00", b_rdy); end
    tick(); b_mrdy = 1'b0; mid();
    vecs++; if (b_busy !== 1'b0) begin miss++; $display("FAIL fix_idle_state got %b want 0", b_busy); end
    tick(); b_acc = 2'b10; mid();
    tick(); b_acc = 2'b11; mid();
    vecs++; if ({b_macc, b_ma} !== {1'b1, B1}) begin miss++; $display("FAIL fix_c1 got %b %h want 1 %h", b_macc, b_ma, B1); end
    tick(); b_mrdy = 1'b1; mid();
    vecs++; if ({b_rdy, b_ma} !== {2'b10, B1}) begin miss++; $display("FAIL fix_c2_nopreempt got %b %h want 10 %h", b_rdy, b_ma, B1); end
    tick(); b_mrdy = 1'b0; b_acc = 2'b01; mid();
    vecs++; if ({b_busy, b_macc} !== 2'b00) begin miss++; $display("FAIL fix_c3_bubble got %b want 00", {b_busy, b_macc}); end
    tick(); mid();
    vecs++; if ({b_macc, b_ma} !== {1'b1, B0}) begin miss++; $display("FAIL fix_c4 got %b %h want 1 %h", b_macc, b_ma, B0); end
    tick(); b_mrdy = 1'b1; mid();
    vecs++; if (b_rdy !== 2'b01) begin miss++; $display("FAIL fix_c5 got %b want 01", b_rdy); end
    tick(); b_mrdy = 1'b0; b_acc = 2'b11; mid();
    tick(); mid();
    vecs++; if (b_ma !== B0) begin miss++; $display("FAIL fix_lowest_wins got %h want %h", b_ma, B0); end
    tick(); b_mrdy = 1'b1; b_acc = 2'b01; mid();
    tick(); b_mrdy = 1'b0; b_acc = 2'b00;
  endtask

  task automatic test_rr3();
    int got [3];
    logic [2:0] exp_rdy;
    got = '{0, 0, 0};
    tick(); c_acc = 3'b111; c_mrdy = 1'b1;
    for (int t = 0; t < 12; t++) begin
      mid();
      exp_rdy = (t % 2 == 1) ? 3'(1 << ((t / 2) % 3)) : 3'b000;
      vecs++; if (c_rdy !== exp_rdy) begin miss++; $display("FAIL rr3_t%0d got %b want %b", t, c_rdy, exp_rdy); end
      for (int k = 0; k < 3; k++) if (c_rdy[k] === 1'b1) got[k]++;
      tick();
    end
    c_acc = 3'b000; c_mrdy = 1'b0;
    vecs++; if ({got[0], got[1], got[2]} !== {32'd2, 32'd2, 32'd2}) begin miss++; $display("FAIL rr3_share got %0d %0d %0d want 2 2 2", got[0], got[1], got[2]); end
  endtask

  task automatic test_store();
    c_addr[63:32] = 32'h1FC0_0010; c_wr = 3'b010; c_sel[7:4] = 4'b0011;
    c_st[63:32] = 32'hDEAD_BEEF; c_size[3:2] = SIZE_WORD;
    tick(); c_acc = 3'b010; mid();
    vecs++; if (c_busy !== 1'b0) begin miss++; $display("FAIL st_c0 got %b want 0", c_busy); end
    tick(); mid();
    vecs++; if ({c_macc, c_mwr, c_ma} !== {2'b11, 32'h1FC0_0010}) begin miss++; $display("FAIL st_addr got %b%b %h want 11 1fc00010", c_macc, c_mwr, c_ma); end
    vecs++; if ({c_msel, c_mst, c_msize} !== {4'b0011, 32'hDEAD_BEEF, SIZE_WORD}) begin miss++; $display("FAIL st_data got %b %h %b want 0011 deadbeef 10", c_msel, c_mst, c_msize); end
    vecs++; if (c_rdy !== 3'b000) begin miss++; $display("FAIL st_early_rdy got %b want 000", c_rdy); end
    tick(); c_mrdy = 1'b1; mid();
    vecs++; if (c_rdy !== 3'b010) begin miss++; $display("FAIL st_rdy got %b want 010", c_rdy); end
    tick(); c_mrdy = 1'b0; c_acc = 3'b000; c_wr = 3'b000; mid();
    vecs++; if (c_rdy !== 3'b000) begin miss++; $display("FAIL st_rdy_pulse got %b want 000", c_rdy); end
  endtask

  task automatic test_async_reset();
    tick(); a_acc = 2'b01;
    tick(); mid();
    vecs++; if (a_busy !== 1'b1) begin miss++; $display("FAIL ar_busy got %b want 1", a_busy); end
    #2;
    a_mrdy = 1'b1; rst_n = 1'b0;
    #1;
    vecs++; if ({a_macc, a_busy, a_rdy} !== 4'b0000) begin miss++; $display("FAIL ar_async got %b want 0000", {a_macc, a_busy, a_rdy}); end
    tick(); a_mrdy = 1'b0; a_acc = 2'b00;
    tick(); rst_n = 1'b1;
    tick(); a_acc = 2'b10; mid();
    vecs++; if (a_busy !== 1'b0) begin miss++; $display("FAIL ar_fresh_c0 got %b want 0", a_busy); end
    tick(); mid();
    vecs++; if ({a_macc, a_ma} !== {1'b1, A1}) begin miss++; $display("FAIL ar_fresh_grant got %b %h want 1 %h", a_macc, a_ma, A1); end
    tick(); a_mrdy = 1'b1; mid();
    vecs++; if (a_rdy !== 2'b10) begin miss++; $display("FAIL ar_fresh_rdy got %b want 10", a_rdy); end
    tick(); a_mrdy = 1'b0; a_acc = 2'b00;
  endtask

  task automatic test_perf();
    logic [7:0] exp_pw, exp_pg1, exp_pg2;
`ifdef MEM_ARB_PERF_EN
    exp_pw = 8'hF1; exp_pg1 = 8'h01; exp_pg2 = 8'h11;
`else
    exp_pw = 8'h00; exp_pg1 = 8'h00; exp_pg2 = 8'h00;
`endif
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); a_acc = 2'b11;
    repeat (21) tick();
    mid();
    vecs++; if (a_pw !== exp_pw) begin miss++; $display("FAIL perf_wait got %h want %h", a_pw, exp_pw); end
    vecs++; if (a_pg !== exp_pg1) begin miss++; $display("FAIL perf_grant1 got %h want %h", a_pg, exp_pg1); end
    tick(); a_mrdy = 1'b1;
    tick(); a_mrdy = 1'b0; a_acc = 2'b10;
    tick();
    tick(); a_mrdy = 1'b1;
    tick(); a_mrdy = 1'b0; a_acc = 2'b00; mid();
    vecs++; if (a_pg !== exp_pg2) begin miss++; $display("FAIL perf_grant2 got %h want %h", a_pg, exp_pg2); end
    vecs++; if (a_pw !== exp_pw) begin miss++; $display("FAIL perf_wait_hold got %h want %h", a_pw, exp_pw); end
  endtask

  initial begin
    test_reset();
    test_rr2();
    test_fixed();
    test_rr3();
    test_store();
    test_async_reset();
    test_perf();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
